dsram_like_responder: RTL

- Responder (slave) end of the data-side SRAM-like interface that the MEM stage consumes through data_sram_data_ok / data_sram_rdata.
- Accepts requests with an addr_ok handshake and keeps up to DEPTH of them outstanding in an in-order queue.
- Returns exactly one data_ok per accepted request after a programmable latency, backed by an internal word-organised RAM with byte strobes.
- Used as the data-memory model for the pipeline bench, and later as a tightly-coupled data RAM.

---
 rtl/dsram_like_responder.sv | 122 ++++++++++++
 1 files changed

// File: rtl/dsram_like_responder.sv
// rtl/dsram_like_responder.sv - SRAM-like data-side responder with in-order response queue
//
// Accepts data-side SRAM-like requests, performs the RAM access at acceptance
// and answers each accepted request with one data_ok pulse, in order, no
// earlier than LATENCY cycles after acceptance.
//
// Ports:
//   clk               clock, all state changes on the rising edge
//   resetn            asynchronous active-low reset
//   data_sram_req     request valid
//   data_sram_wr      1 = write, 0 = read
//   data_sram_size    access size (informational; wstrb is authoritative)
//   data_sram_wstrb   byte enables for writes
//   data_sram_addr    byte address
//   data_sram_wdata   lane-aligned write data
//   data_sram_addr_ok request accepted when high together with req
//   data_sram_data_ok one-cycle response pulse per accepted request
//   data_sram_rdata   full aligned word for read responses, 0 otherwise

module dsram_like_responder #(
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 2,
    parameter int DEPTH     = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata
);

    localparam int IW = $clog2(MEM_WORDS);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(LATENCY + 1);

    logic [31:0]   mem [MEM_WORDS];
    logic [31:0]   ent_rdata [DEPTH];
    logic [AW-1:0] ent_age [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic [IW-1:0] idx;
    logic          accept;
    logic          retire;

    // Address bits outside the word index and the size field are deliberately ignored.
    logic unused_bits;
    assign unused_bits = ^{data_sram_size, data_sram_addr[31:IW+2], data_sram_addr[1:0]};

    assign idx = data_sram_addr[IW+1:2];

    // No bypass: a full queue refuses requests even when the head retires this cycle.
    assign data_sram_addr_ok = resetn && (count < CW'(DEPTH));
    assign accept            = data_sram_req && data_sram_addr_ok;

    // Age counts cycles since acceptance, so the head is due once it reaches LATENCY.
    assign retire            = resetn && (count != '0) && (ent_age[rd_ptr] == AW'(LATENCY));
    assign data_sram_data_ok = retire;
    assign data_sram_rdata   = retire ? ent_rdata[rd_ptr] : 32'h0;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // RAM is not reset; byte-strobed write lands on the edge ending the accept cycle.
    always_ff @(posedge clk) begin
        if (accept && data_sram_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (data_sram_wstrb[b]) begin
                    mem[idx][b*8 +: 8] <= data_sram_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Read data is captured at acceptance, so later writes cannot disturb queued entries.
    always_ff @(posedge clk) begin
        if (accept) begin
            ent_rdata[wr_ptr] <= data_sram_wr ? 32'h0 : mem[idx];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_age[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (accept && (wr_ptr == PW'(i))) begin
                    // One edge has passed by the first cycle this entry is visible.
                    ent_age[i] <= AW'(1);
                end else if (ent_age[i] != AW'(LATENCY)) begin
                    ent_age[i] <= ent_age[i] + AW'(1);
                end
            end
            if (accept) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (retire) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({accept, retire})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
